// File: rtl/serv_lsu_pkg.sv
// serv_lsu_pkg
//   Shared encodings for the serial load/store unit: FSM states, access
//   size, Wishbone byte-lane constants and small helpers for lane select,
//   byte rotation and load extension.
package serv_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ST_SHIFT = 3'd1,
        REQ      = 3'd2,
        LD_SHIFT = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_BYTE0   = 4'b0001;

    function automatic logic [3:0] lane_sel(input size_t size, input logic [1:0] lsb);
        logic [3:0] sel;
        case (size)
            SZ_WORD: sel = SEL_WORD;
            SZ_HALF: sel = lsb[1] ? SEL_HALF_HI : SEL_HALF_LO;
            default: sel = SEL_BYTE0 << lsb;
        endcase
        return sel;
    endfunction

    // Rotate left by 8*lsb bits (places the store data on its byte lanes).
    function automatic logic [31:0] rot_left(input logic [31:0] d, input logic [1:0] lsb);
        logic [31:0] r;
        case (lsb)
            2'd1:    r = {d[23:0], d[31:24]};
            2'd2:    r = {d[15:0], d[31:16]};
            2'd3:    r = {d[7:0],  d[31:8]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Rotate right by 8*lsb bits (brings the addressed lane down to bit 0).
    function automatic logic [31:0] rot_right(input logic [31:0] d, input logic [1:0] lsb);
        logic [31:0] r;
        case (lsb)
            2'd1:    r = {d[7:0],  d[31:8]};
            2'd2:    r = {d[15:0], d[31:16]};
            2'd3:    r = {d[23:0], d[31:24]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] d, input size_t size,
                                                input logic sgn);
        logic [31:0] r;
        case (size)
            SZ_WORD: r = d;
            SZ_HALF: r = {{16{sgn & d[15]}}, d[15:0]};
            default: r = {{24{sgn & d[7]}}, d[7:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serv_lsu_shreg.sv
// serv_lsu_shreg
//   32-bit data register with parallel load and W-bit serial shift.
//   Shifting moves data towards bit 0 and inserts i_dat at the top, so the
//   first chunk shifted in ends up in the LSBs after 32/W shifts, and o_q[W-1:0]
//   is always the next chunk to be shifted out.
// Ports
//   i_clk, i_rst_n  clock, async active-low reset
//   i_load          parallel load of i_load_dat (wins over i_shift)
//   i_load_dat      32-bit parallel data
//   i_shift         shift by W bits
//   i_dat           W-bit chunk inserted at the top
//   o_q             register contents
module serv_lsu_shreg #(
    parameter int W = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [31:0]   i_load_dat,
    input  logic          i_shift,
    input  logic [W-1:0]  i_dat,
    output logic [31:0]   o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_q <= '0;
        else if (i_load)
            o_q <= i_load_dat;
        else if (i_shift)
            o_q <= {i_dat, o_q[31:W]};
    end

endmodule

// File: rtl/serv_lsu.sv
// serv_lsu
//   Serial load/store unit: gathers store data W bits per cycle, issues one
//   Wishbone access, and returns load data W bits per cycle, LSB first.
//   Optional macro SERV_LSU_TIMEOUT_EN adds a bus timeout of TIMEOUT cycles;
//   without it the bus phase waits for ack indefinitely and o_err stays 0.
// Ports
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_start                           request pulse (accepted only in IDLE)
//   i_we, i_word, i_half, i_signed    store/load, size, sign-extend loads
//   i_lsb                             address bits [1:0]
//   i_dat / o_rd, o_rd_valid          serial store / load data
//   o_busy, o_done, o_misalign, o_err status (flags valid with o_done)
//   o_wb_*, i_wb_rdt, i_wb_ack        Wishbone master
//
// state    | meaning
// IDLE     | waiting for i_start
// ST_SHIFT | shifting N store chunks into the data register
// REQ      | bus cycle in progress, waiting for ack (or timeout)
// LD_SHIFT | shifting N load chunks out on o_rd
// DONE     | one-cycle completion pulse
module serv_lsu
    import serv_lsu_pkg::*;
#(
    parameter int W        = 1,
    parameter int WITH_CSR = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_we,
    input  logic          i_word,
    input  logic          i_half,
    input  logic          i_signed,
    input  logic [1:0]    i_lsb,
    input  logic [W-1:0]  i_dat,
    output logic [W-1:0]  o_rd,
    output logic          o_rd_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_misalign,
    output logic          o_err,
    output logic          o_wb_cyc,
    output logic          o_wb_we,
    output logic [3:0]    o_wb_sel,
    output logic [31:0]   o_wb_dat,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack
);

    localparam int N  = 32 / W;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, next_state;
    size_t         start_size, size_q;
    logic          we_q, signed_q, misalign_q, err_q, cyc_q;
    logic [1:0]    lsb_q;
    logic [CW-1:0] cnt;
    logic [31:0]   data_q;
    logic          misaligned, ack, timeout;

    assign start_size = i_word ? SZ_WORD : (i_half ? SZ_HALF : SZ_BYTE);
    assign misaligned = (WITH_CSR != 0) &&
                        ((i_lsb[0] && (start_size != SZ_BYTE)) ||
                         (i_lsb[1] && (start_size == SZ_WORD)));
    // Acks outside an active bus cycle are not ours.
    assign ack = cyc_q & i_wb_ack;

`ifdef SERV_LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            tmo_cnt <= '0;
        else if (state != REQ)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Fires on the last allowed REQ cycle; an ack in that same cycle wins.
    assign timeout = (state == REQ) && !ack && (tmo_cnt == T_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:
                if (i_start)
                    next_state = misaligned ? DONE : (i_we ? ST_SHIFT : REQ);
            ST_SHIFT:
                if (cnt == LAST) next_state = REQ;
            REQ:
                if (ack)          next_state = we_q ? DONE : LD_SHIFT;
                else if (timeout) next_state = DONE;
            LD_SHIFT:
                if (cnt == LAST) next_state = DONE;
            DONE:
                next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            lsb_q      <= 2'd0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            cyc_q <= (next_state == REQ);
            if (state == IDLE && i_start) begin
                we_q       <= i_we;
                size_q     <= start_size;
                signed_q   <= i_signed;
                lsb_q      <= i_lsb;
                misalign_q <= misaligned;
                err_q      <= 1'b0;
            end
            if (timeout)
                err_q <= 1'b1;
            // Counter is exactly CW bits wide, so it wraps to 0 after LAST.
            if (state == ST_SHIFT || state == LD_SHIFT)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    serv_lsu_shreg #(.W(W)) u_shreg (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (ack && !we_q),
        .i_load_dat (extend_load(rot_right(i_wb_rdt, lsb_q), size_q, signed_q)),
        .i_shift    ((state == ST_SHIFT) || (state == LD_SHIFT)),
        .i_dat      ((state == ST_SHIFT) ? i_dat : '0),
        .o_q        (data_q)
    );

    always_comb begin
        o_busy     = (state != IDLE);
        o_done     = (state == DONE);
        o_rd_valid = (state == LD_SHIFT);
        o_rd       = o_rd_valid ? data_q[W-1:0] : '0;
        o_misalign = o_done & misalign_q;
        o_err      = o_done & err_q;
        o_wb_cyc   = cyc_q;
        o_wb_we    = we_q;
        o_wb_sel   = cyc_q ? lane_sel(size_q, lsb_q) : 4'b0000;
        o_wb_dat   = rot_left(data_q, lsb_q);
    end

endmodule

// File: tb/tb_serv_lsu.sv
module tb_serv_lsu;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start, i_we, i_word, i_half, i_signed;
    logic [1:0]  i_lsb;
    logic [3:0]  i_dat;
    logic [3:0]  o_rd;
    logic        o_rd_valid, o_busy, o_done, o_misalign, o_err;
    logic        o_wb_cyc, o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat, i_wb_rdt;
    logic        i_wb_ack;

    int n_pass  = 0;
    int n_total = 0;

    serv_lsu #(.W(4), .WITH_CSR(1), .TIMEOUT(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_we       (i_we),
        .i_word     (i_word),
        .i_half     (i_half),
        .i_signed   (i_signed),
        .i_lsb      (i_lsb),
        .i_dat      (i_dat),
        .o_rd       (o_rd),
        .o_rd_valid (o_rd_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_misalign (o_misalign),
        .o_err      (o_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_we    (o_wb_we),
        .o_wb_sel   (o_wb_sel),
        .o_wb_dat   (o_wb_dat),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic        we, word, half, sgn;
        logic [1:0]  lsb;
        logic [31:0] wdat;
        logic [31:0] rdt;
        int          delay;
        logic        mis;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        logic [31:0] got;
        int          nvalid;
        i_start = 1'b1; i_we = v.we; i_word = v.word; i_half = v.half;
        i_signed = v.sgn; i_lsb = v.lsb;
        tick();
        i_start = 1'b0;
        if (v.mis) begin
            check({tag, " mis_done"}, {30'b0, o_done, o_misalign}, 32'h3);
            check({tag, " mis_nocyc"}, {31'b0, o_wb_cyc}, 32'h0);
            tick();
            check({tag, " mis_idle"}, {30'b0, o_busy, o_done}, 32'h0);
            return;
        end
        if (v.we) begin
            for (int k = 0; k < 8; k++) begin
                if (k == 7) check({tag, " shift_len"}, {31'b0, o_wb_cyc}, 32'h0);
                i_dat = v.wdat[4*k +: 4];
                tick();
            end
            i_dat = 4'h0;
        end
        check({tag, " cyc_we"}, {30'b0, o_wb_cyc, o_wb_we}, {30'b0, 1'b1, v.we});
        check({tag, " sel"}, {28'b0, o_wb_sel}, {28'b0, v.sel});
        if (v.we) check({tag, " wb_dat"}, o_wb_dat, v.exp);
        for (int k = 1; k < v.delay; k++) tick();
        i_wb_ack = 1'b1; i_wb_rdt = v.rdt;
        tick();
        i_wb_ack = 1'b0; i_wb_rdt = 32'h0;
        check({tag, " cyc_drop"}, {31'b0, o_wb_cyc}, 32'h0);
        if (!v.we) begin
            got = 32'h0; nvalid = 0;
            for (int k = 0; k < 8; k++) begin
                if (o_rd_valid) nvalid++;
                got[4*k +: 4] = o_rd;
                tick();
            end
            check({tag, " rd_chunks"}, nvalid, 32'd8);
            check({tag, " rd_data"}, got, v.exp);
        end
        check({tag, " done_flags"}, {24'b0, o_done, o_err, o_misalign, o_rd_valid, o_rd},
              {24'b0, 8'b1000_0000});
        tick();
        check({tag, " after_done"}, {30'b0, o_busy, o_done}, 32'h0);
    endtask

    int   cnt;
    logic seen;

    initial begin
        // we word half sgn lsb wdat rdt delay mis sel exp
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 2, 1'b0, 4'b1111, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'hCAFE00A5, 32'h0, 1, 1'b0, 4'b1000, 32'hA5CAFE00};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h56781234, 32'h0, 3, 1'b0, 4'b1100, 32'h12345678};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h00800000, 2, 1'b0, 4'b0100, 32'hFFFFFF80};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'hABCD0000, 1, 1'b0, 4'b1100, 32'h0000ABCD};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h12348001, 3, 1'b0, 4'b0011, 32'hFFFF8001};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h89ABCDEF, 1, 1'b0, 4'b1111, 32'h89ABCDEF};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 32'h1122F344, 2, 1'b0, 4'b0010, 32'h000000F3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 32'h7F000000, 1, 1'b0, 4'b1000, 32'h0000007F};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0, 32'h0, 1, 1'b1, 4'b0000, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 1, 1'b1, 4'b0000, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1, 1'b1, 4'b0000, 32'h0};

        i_rst_n = 1'b0; i_start = 1'b0; i_we = 1'b0; i_word = 1'b0; i_half = 1'b0;
        i_signed = 1'b0; i_lsb = 2'd0; i_dat = 4'h0; i_wb_rdt = 32'h0; i_wb_ack = 1'b0;
        #12;
        check("reset_outputs",
              {20'b0, o_busy, o_done, o_misalign, o_err, o_wb_cyc, o_wb_we, o_rd_valid,
               o_wb_sel, 1'b0},
              32'h0);
        check("reset_wb_dat_rd", o_wb_dat | {28'b0, o_rd}, 32'h0);

        // First start is taken on the first edge after reset release.
        i_start = 1'b1; i_word = 1'b1;
        #1 i_rst_n = 1'b1;
        tick();
        i_start = 1'b0; i_word = 1'b0;
        check("first_start", {30'b0, o_busy, o_wb_cyc}, 32'h3);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h13579BDF;
        tick();
        i_wb_ack = 1'b0;
        for (int k = 0; k < 20 && o_busy; k++) tick();
        check("first_start_finish", {31'b0, o_busy}, 32'h0);

        for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Ack with no bus cycle open must not start anything.
        i_wb_ack = 1'b1;
        tick(); tick();
        i_wb_ack = 1'b0;
        check("stray_ack", {29'b0, o_busy, o_done, o_rd_valid}, 32'h0);

        // Start while busy is ignored; the latched request is kept.
        i_start = 1'b1; i_we = 1'b0; i_word = 1'b1; i_lsb = 2'd0;
        tick();
        i_we = 1'b1; i_word = 1'b0; i_lsb = 2'd1;
        tick();
        i_start = 1'b0;
        check("busy_start_sel", {27'b0, o_wb_we, o_wb_sel}, {27'b0, 1'b0, 4'b1111});
        i_wb_ack = 1'b1; i_wb_rdt = 32'h0;
        tick();
        i_wb_ack = 1'b0;
        check("busy_start_load", {31'b0, o_rd_valid}, 32'h1);
        for (int k = 0; k < 20 && o_busy; k++) tick();
        tick();
        check("busy_start_norestart", {31'b0, o_busy}, 32'h0);

        // Reset in the middle of a bus cycle.
        i_start = 1'b1; i_we = 1'b0; i_word = 1'b1; i_lsb = 2'd0;
        tick();
        i_start = 1'b0;
        tick();
        check("midreq_cyc", {31'b0, o_wb_cyc}, 32'h1);
        #2 i_rst_n = 1'b0;
        #1;
        check("midreq_reset", {26'b0, o_wb_cyc, o_busy, o_wb_sel}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen = seen | o_done;
        end
        check("midreq_nodone", {31'b0, seen}, 32'h0);
        i_rst_n = 1'b1;
        tick();
        do_txn(vecs[0], "after_reset");

`ifdef SERV_LSU_TIMEOUT_EN
        i_start = 1'b1; i_we = 1'b0; i_word = 1'b1; i_lsb = 2'd0;
        tick();
        i_start = 1'b0;
        cnt = 0; seen = 1'b0;
        while (o_wb_cyc && cnt < 20) begin
            cnt++;
            tick();
        end
        check("tmo_cyc_len", cnt, 32'd4);
        check("tmo_done_err", {29'b0, o_done, o_err, o_rd_valid}, 32'h6);
        tick();
        check("tmo_idle", {31'b0, o_busy}, 32'h0);
        vecs[6].delay = 4;
        do_txn(vecs[6], "ack_on_expiry");
`else
        vecs[6].delay = 12;
        do_txn(vecs[6], "long_wait");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
